// File: rtl/ir_arb_pkg.sv
// Shared types and constants for the impulse-response BRAM arbiter.
package ir_arb_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CLEAR_DRAIN = 2'd1,
        CLEAR       = 2'd2
    } arb_state_t;

    localparam int STALL_W = 16;
    localparam int GRANT_W = 32;

endpackage

// File: rtl/ir_arb_read_pipe.sv
// Read-return alignment: tracks accepted reads through the BRAM latency and
// substitutes zero for out-of-range reads.
module ir_arb_read_pipe #(
    parameter int RD_LATENCY = 2,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              push_oob,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid
);

    logic [RD_LATENCY:0] vld_r;
    logic [RD_LATENCY:0] oob_r;

    // Stage 0 lines up with the registered mem_en; the last stage with mem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            oob_r <= '0;
        end else begin
            vld_r <= {vld_r[RD_LATENCY-1:0], push};
            oob_r <= {oob_r[RD_LATENCY-1:0], push & push_oob};
        end
    end

    assign rd_data_valid = vld_r[RD_LATENCY];

    // Return data mux: zero for out-of-range or idle slots.
    always_comb begin
        if (vld_r[RD_LATENCY] && !oob_r[RD_LATENCY]) begin
            rd_data = mem_rdata;
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/ir_bram_arbiter.sv
// Single-port IR BRAM arbiter: writer-priority access plus a full-memory clear sweep.
// Optional statistics counters are built when IR_ARB_STATS_EN is defined.
module ir_bram_arbiter
    import ir_arb_pkg::*;
#(
    parameter int DEPTH      = 24000,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic              audio_clk,
    input  logic              rst_in_n,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              oob_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef IR_ARB_STATS_EN
    ,
    output logic [STALL_W-1:0] wr_stall_cycles,
    output logic [GRANT_W-1:0] rd_grant_count
`endif
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    arb_state_t        state_r;
    arb_state_t        state_nx_s;
    logic              ready_r;
    logic              clear_busy_r;
    logic              oob_err_r;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              wr_hs_s;
    logic              rd_hs_s;
    logic              wr_oob_s;
    logic              rd_oob_s;

    // The accepted write occupies the port registers for one cycle, which is the
    // hold slot; ready_r is low while it is full or the sweep owns the port.
    assign wr_ready = ready_r;
    assign rd_ready = ready_r & ~wr_valid;
    assign wr_hs_s  = wr_valid & ready_r;
    assign rd_hs_s  = rd_valid & rd_ready;
    assign wr_oob_s = (wr_addr >= DEPTH_A);
    assign rd_oob_s = (rd_addr >= DEPTH_A);

    // Next-state decode for the clear sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (clear_req) begin
                    state_nx_s = CLEAR_DRAIN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CLEAR_DRAIN: state_nx_s = CLEAR;
            CLEAR: begin
                if (clr_cnt_r == LAST_A) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = CLEAR;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Sequencer state, handshake flags and the registered memory port.
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_r      <= IDLE;
            ready_r      <= 1'b0;
            clear_busy_r <= 1'b0;
            oob_err_r    <= 1'b0;
            clr_cnt_r    <= '0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
        end else begin
            state_r      <= state_nx_s;
            ready_r      <= (state_nx_s == IDLE) && !wr_hs_s;
            clear_busy_r <= (state_nx_s != IDLE);
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            if (state_r == CLEAR_DRAIN) begin
                mem_en_r    <= 1'b1;
                mem_we_r    <= 1'b1;
                mem_addr_r  <= '0;
                mem_wdata_r <= '0;
                clr_cnt_r   <= '0;
            end else if (state_r == CLEAR) begin
                // clr_cnt_r names the address currently on the port.
                if (clr_cnt_r != LAST_A) begin
                    mem_en_r    <= 1'b1;
                    mem_we_r    <= 1'b1;
                    mem_addr_r  <= clr_cnt_r + ADDR_W'(1);
                    mem_wdata_r <= '0;
                    clr_cnt_r   <= clr_cnt_r + ADDR_W'(1);
                end else begin
                    clr_cnt_r <= '0;
                end
            end else if (wr_hs_s) begin
                if (!wr_oob_s) begin
                    mem_en_r    <= 1'b1;
                    mem_we_r    <= 1'b1;
                    mem_addr_r  <= wr_addr;
                    mem_wdata_r <= wr_data;
                end else begin
                    oob_err_r <= 1'b1;
                end
            end else if (rd_hs_s) begin
                if (!rd_oob_s) begin
                    mem_en_r   <= 1'b1;
                    mem_addr_r <= rd_addr;
                end else begin
                    oob_err_r <= 1'b1;
                end
            end
        end
    end

    assign clear_busy = clear_busy_r;
    assign oob_err    = oob_err_r;
    assign mem_en     = mem_en_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

    ir_arb_read_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .DATA_W     (DATA_W)
    ) u_read_pipe (
        .clk           (audio_clk),
        .rst_n         (rst_in_n),
        .push          (rd_hs_s),
        .push_oob      (rd_oob_s),
        .mem_rdata     (mem_rdata),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid)
    );

`ifdef IR_ARB_STATS_EN
    logic [STALL_W-1:0] stall_r;
    logic [GRANT_W-1:0] grant_r;

    // Saturating activity counters, zeroed by any clear request.
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            stall_r <= '0;
            grant_r <= '0;
        end else if (clear_req) begin
            stall_r <= '0;
            grant_r <= '0;
        end else begin
            if (wr_valid && !ready_r && (stall_r != {STALL_W{1'b1}})) begin
                stall_r <= stall_r + STALL_W'(1);
            end
            if (rd_hs_s && (grant_r != {GRANT_W{1'b1}})) begin
                grant_r <= grant_r + GRANT_W'(1);
            end
        end
    end

    assign wr_stall_cycles = stall_r;
    assign rd_grant_count  = grant_r;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ir_bram_arbiter.sv
// Bench for ir_bram_arbiter: timeline model of expected port activity plus directed scenarios.
module tb_ir_bram_arbiter;

    localparam int DEPTH = 24000;
    localparam int LAT   = 2;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int NEVER = 32'h7fff_ffff;

    logic          audio_clk = 1'b0;
    logic          rst_in_n  = 1'b0;
    logic          clear_req = 1'b0;
    logic          wr_valid  = 1'b0;
    logic          rd_valid  = 1'b0;
    logic [AW-1:0] wr_addr   = '0;
    logic [AW-1:0] rd_addr   = '0;
    logic [DW-1:0] wr_data   = '0;
    logic          clear_busy, wr_ready, rd_ready, rd_data_valid, oob_err, mem_en, mem_we;
    logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int errors = 0;

    ir_bram_arbiter dut (
        .audio_clk(audio_clk), .rst_in_n(rst_in_n), .clear_req(clear_req), .clear_busy(clear_busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .oob_err(oob_err), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 audio_clk = ~audio_clk;

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(32'hA000 + i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Behavioural BRAM: two-cycle read latency from mem_en.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] q1;
    initial for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
    always @(posedge audio_clk) begin
        if (mem_en && (int'(mem_addr) < DEPTH)) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        q1 <= ram[mem_addr];
        end
        mem_rdata <= q1;
    end

    // Timeline model: cycle numbers at which each port event must appear.
    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } op_t;
    op_t           exp_op  [int];
    logic [DW-1:0] exp_rdv [int];
    logic [DW-1:0] shadow  [DEPTH];
    int  cyc = 0, ready_cyc = NEVER, idle_cyc = NEVER, clr_start = NEVER, oob_from = NEVER;
    bit  in_rst = 1'b1;
    bit  m_wh, m_rh;
    op_t mo;
    int  p;

    initial for (int i = 0; i < DEPTH; i++) shadow[i] = pat(i);

    always @(posedge audio_clk) begin
        cyc = cyc + 1;
        p = cyc - 1;
        if (!rst_in_n) begin
            in_rst = 1'b1;
            exp_op.delete();
            exp_rdv.delete();
            clr_start = NEVER; oob_from = NEVER; ready_cyc = NEVER; idle_cyc = NEVER;
        end else if (in_rst) begin
            in_rst = 1'b0;
            ready_cyc = cyc;
            idle_cyc  = cyc;
        end else begin
            if (clr_start != NEVER && p >= clr_start + 1 && p <= clr_start + DEPTH)
                shadow[p - clr_start - 1] = '0;
            m_wh = wr_valid && (p >= ready_cyc);
            m_rh = rd_valid && !wr_valid && (p >= ready_cyc);
            if (m_wh) begin
                if (int'(wr_addr) < DEPTH) begin
                    mo.we = 1'b1; mo.addr = wr_addr; mo.data = wr_data;
                    exp_op[cyc] = mo;
                    shadow[wr_addr] = wr_data;
                end else if (oob_from == NEVER) begin
                    oob_from = cyc;
                end
                if (ready_cyc < cyc + 1) ready_cyc = cyc + 1;
            end
            if (m_rh) begin
                if (int'(rd_addr) < DEPTH) begin
                    mo.we = 1'b0; mo.addr = rd_addr; mo.data = '0;
                    exp_op[cyc] = mo;
                    exp_rdv[cyc + LAT] = shadow[rd_addr];
                end else begin
                    exp_rdv[cyc + LAT] = '0;
                    if (oob_from == NEVER) oob_from = cyc;
                end
            end
            if (clear_req && p >= idle_cyc) begin
                clr_start = cyc;
                idle_cyc  = cyc + 1 + DEPTH;
                if (ready_cyc < idle_cyc) ready_cyc = idle_cyc;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_wdata = '0;
    bit  c_has, c_busy, c_rv;
    op_t co;
    always @(negedge audio_clk) begin
        if (!rst_in_n || in_rst) begin
            last_addr = '0; last_wdata = '0;
            chk("rst_mem_en", 32'(mem_en), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            chk("rst_rd_valid", 32'(rd_data_valid), 32'd0);
            chk("rst_rd_data", 32'(rd_data), 32'd0);
            chk("rst_wr_ready", 32'(wr_ready), 32'd0);
            chk("rst_rd_ready", 32'(rd_ready), 32'd0);
            chk("rst_clear_busy", 32'(clear_busy), 32'd0);
            chk("rst_oob_err", 32'(oob_err), 32'd0);
        end else begin
            c_has = 1'b0;
            co.we = 1'b0; co.addr = '0; co.data = '0;
            c_busy = (clr_start != NEVER) && cyc >= clr_start && cyc <= clr_start + DEPTH;
            if (exp_op.exists(cyc)) begin
                co = exp_op[cyc]; c_has = 1'b1; exp_op.delete(cyc);
            end else if (c_busy && cyc >= clr_start + 1) begin
                co.we = 1'b1; co.addr = AW'(cyc - clr_start - 1); co.data = '0; c_has = 1'b1;
            end
            if (c_has) last_addr = co.addr;
            if (c_has && co.we) last_wdata = co.data;
            chk("mem_en", 32'(mem_en), 32'(c_has));
            chk("mem_we", 32'(mem_we), 32'(c_has && co.we));
            chk("mem_addr", 32'(mem_addr), 32'(last_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(last_wdata));
            c_rv = exp_rdv.exists(cyc);
            chk("rd_data_valid", 32'(rd_data_valid), 32'(c_rv));
            if (c_rv) begin
                chk("rd_data", 32'(rd_data), 32'(exp_rdv[cyc]));
                exp_rdv.delete(cyc);
            end
            chk("wr_ready", 32'(wr_ready), 32'(cyc >= ready_cyc));
            chk("rd_ready", 32'(rd_ready), 32'(cyc >= ready_cyc && !wr_valid));
            chk("clear_busy", 32'(clear_busy), 32'(c_busy));
            chk("oob_err", 32'(oob_err), 32'(cyc >= oob_from));
        end
    end

    // Observers feeding the hand-computed scenario checks.
    typedef struct { int c; logic [DW-1:0] d; } rv_t;
    rv_t rdv_q [$];
    int  busy_cnt = 0, zero_cnt = 0;
    always @(negedge audio_clk) begin
        if (rst_in_n && rd_data_valid) rdv_q.push_back('{cyc, rd_data});
        if (rst_in_n && clear_busy) busy_cnt++;
        if (rst_in_n && clear_busy && mem_en && mem_we && mem_wdata == '0 && mem_addr == AW'(zero_cnt))
            zero_cnt++;
    end

    task automatic tick();
        @(posedge audio_clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, input bit with_clear);
        bit ok = 1'b0;
        wr_addr = AW'(a); wr_data = d; wr_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            #1;
            if (wr_ready) begin ok = 1'b1; clear_req = with_clear; end
            tick();
        end
        wr_valid = 1'b0; clear_req = 1'b0;
        if (!ok) chk("wr_timeout", 32'd0, 32'd1);
    endtask

    task automatic traffic(input int rs, input int rn, input int wat, input int wa,
                           input logic [DW-1:0] wd, output int first_acc);
        int  ptr = 0, i = 0;
        bit  wdone = (wat < 0);
        bit  rh, wh;
        first_acc = -1;
        while ((ptr < rn || !wdone) && i < 200) begin
            rd_valid = (ptr < rn); rd_addr = AW'(rs + ptr);
            wr_valid = !wdone && (i >= wat); wr_addr = AW'(wa); wr_data = wd;
            #1;
            rh = rd_valid && rd_ready; wh = wr_valid && wr_ready;
            if (rh && first_acc < 0) first_acc = cyc;
            tick();
            if (rh) ptr++;
            if (wh) wdone = 1'b1;
            i++;
        end
        rd_valid = 1'b0; wr_valid = 1'b0;
        if (i >= 200) chk("traffic_timeout", 32'd0, 32'd1);
        repeat (LAT + 3) tick();
    endtask

    int fa;

    initial begin
        repeat (3) tick();
        chk("lit_rst_wr_ready", 32'(wr_ready), 32'd0);
        rst_in_n = 1'b1;
        repeat (2) tick();
        chk("lit_ready_after_rst", 32'(wr_ready), 32'd1);

        do_write(5, 16'h1234, 1'b0);
        chk("lit_w1_we", 32'(mem_we), 32'd1);
        chk("lit_w1_addr", 32'(mem_addr), 32'd5);
        chk("lit_w1_data", 32'(mem_wdata), 32'h1234);

        rdv_q.delete();
        traffic(0, 8, -1, 0, '0, fa);
        chk("lit_burst_count", 32'(rdv_q.size()), 32'd8);
        if (rdv_q.size() == 8) begin
            chk("lit_burst_latency", 32'(rdv_q[0].c - fa), 32'd3);
            for (int i = 0; i < 8; i++) begin
                chk("lit_burst_seq", 32'(rdv_q[i].c - rdv_q[0].c), 32'(i));
                chk("lit_burst_data", 32'(rdv_q[i].d), (i == 5) ? 32'h1234 : 32'(pat(i)));
            end
        end

        rdv_q.delete();
        traffic(16, 12, 3, 100, 16'h5555, fa);
        chk("lit_mix_count", 32'(rdv_q.size()), 32'd12);
        if (rdv_q.size() == 12)
            for (int i = 0; i < 12; i++) chk("lit_mix_data", 32'(rdv_q[i].d), 32'(pat(16 + i)));

        rdv_q.delete();
        traffic(24000, 1, -1, 0, '0, fa);
        chk("lit_oob_count", 32'(rdv_q.size()), 32'd1);
        if (rdv_q.size() == 1) begin
            chk("lit_oob_data", 32'(rdv_q[0].d), 32'd0);
            chk("lit_oob_latency", 32'(rdv_q[0].c - fa), 32'd3);
        end
        chk("lit_oob_err", 32'(oob_err), 32'd1);
        do_write(24001, 16'hDEAD, 1'b0);
        rdv_q.delete();
        traffic(100, 1, -1, 0, '0, fa);
        if (rdv_q.size() == 1) chk("lit_rb100", 32'(rdv_q[0].d), 32'h5555);
        else chk("lit_rb100_count", 32'(rdv_q.size()), 32'd1);
        chk("lit_oob_sticky", 32'(oob_err), 32'd1);

        busy_cnt = 0; zero_cnt = 0;
        do_write(7, 16'h0BAD, 1'b1);
        chk("lit_drain_we", 32'(mem_we), 32'd1);
        chk("lit_drain_addr", 32'(mem_addr), 32'd7);
        chk("lit_drain_data", 32'(mem_wdata), 32'h0BAD);
        chk("lit_drain_busy", 32'(clear_busy), 32'd1);
        repeat (100) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int t = 0; t < 30000 && clear_busy; t++) tick();
        if (clear_busy) chk("clear_timeout", 32'd0, 32'd1);
        chk("lit_busy_span", 32'(busy_cnt), 32'd24001);
        chk("lit_zero_writes", 32'(zero_cnt), 32'd24000);
        chk("lit_ready_after_clear", 32'(wr_ready), 32'd1);
        rdv_q.delete();
        traffic(5, 3, -1, 0, '0, fa);
        chk("lit_clr_rb_count", 32'(rdv_q.size()), 32'd3);
        for (int i = 0; i < rdv_q.size(); i++) chk("lit_clr_rb", 32'(rdv_q[i].d), 32'd0);

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (50) tick();
        rst_in_n = 1'b0;
        #1;
        chk("lit_async_busy", 32'(clear_busy), 32'd0);
        chk("lit_async_mem_en", 32'(mem_en), 32'd0);
        repeat (2) tick();
        rst_in_n = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            rd_valid = 1'b1; rd_addr = AW'(i);
            tick();
        end
        rd_valid = 1'b0;
        rst_in_n = 1'b0;
        #1;
        chk("lit_async_rdv", 32'(rd_data_valid), 32'd0);
        repeat (2) tick();
        rst_in_n = 1'b1;
        rdv_q.delete();
        repeat (10) tick();
        chk("lit_no_stale_rdv", 32'(rdv_q.size()), 32'd0);
        traffic(3, 2, -1, 0, '0, fa);
        chk("lit_post_rst_count", 32'(rdv_q.size()), 32'd2);
        for (int i = 0; i < rdv_q.size(); i++) chk("lit_post_rst_data", 32'(rdv_q[i].d), 32'd0);
        chk("lit_oob_cleared", 32'(oob_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
